// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared constants, entry type and helpers for the register-bank write-back
// queue (writeback_queue and its storage sub-module wb_fifo).
//   REG_ZERO   : architectural x0. It is never written to the bank, because the
//                bank decodes rd = 0 as reg31.
//   WB_WRITE   : level of the bank's active-low write strobe that writes.
//   WB_IDLE    : level of the same strobe that does not write.
//   wb_entry_t : one buffered write {rd, data}.
//   rd_match   : source/destination compare that never matches x0.
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       WB_WRITE = 1'b0;
    localparam logic       WB_IDLE  = 1'b1;
    localparam int         WB_XLEN  = 32;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // x0 is never produced by the queue, so a query for it never matches.
    function automatic logic rd_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rs != REG_ZERO) && (rs == rd);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Storage for the write-back queue. Pointers wrap modulo DEPTH, and count is
// the only full/empty discriminator. Every entry is exported in age order so
// that the top level can build its pending scoreboard and forwarding logic.
//   clock, reset        : clock and asynchronous active-high reset
//   push, push_rd/data  : store one entry at the tail
//   pop                 : drop the head entry (the caller guarantees count != 0)
//   head_rd/head_data   : oldest entry
//   count               : occupancy, 0..DEPTH
//   age_valid/rd/data   : slot k is the k-th oldest entry (k = 0 is the head)
// ----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [4:0]                 push_rd,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    output logic [4:0]                 head_rd,
    output logic [XLEN-1:0]            head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           age_valid,
    output logic [DEPTH-1:0][4:0]      age_rd,
    output logic [DEPTH-1:0][XLEN-1:0] age_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;

    // The contents need no reset: count alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        // A push and a pop in the same cycle leave the occupancy unchanged.
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign count     = count_reg;

    // The PW-bit addition wraps naturally because DEPTH is a power of two.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PW-1:0] slot;
        assign slot          = rd_ptr_reg + PW'(gi);
        assign age_valid[gi] = CW'(gi) < count_reg;
        assign age_rd[gi]    = rd_mem[slot];
        assign age_data[gi]  = data_mem[slot];
    end

endmodule

// File: rtl/writeback_queue.sv
// ----------------------------------------------------------------------------
// writeback_queue
// Write-side driver for the 32x32 register bank. The queue takes results from
// the load and ALU paths (at most one per cycle, load first) and buffers them
// in wb_fifo. It then serialises them onto the bank's single write port. The
// bank write strobe is active-low. Writes to x0 are accepted but dropped.
// Decode uses the pending scoreboard for rs1/rs2 to decide when to stall.
// Optional macro WB_BYPASS_EN adds the forwarding outputs rs1Fwd/rs2Fwd and
// rs1Hit/rs2Hit.
// Ports:
//   clock, reset             : clock and asynchronous active-high reset
//   aluValid/aluRd/aluData   : ALU result offer; aluReady = accepted this cycle
//   ldValid/ldRd/ldData      : load result offer; ldReady = accepted this cycle
//   drainHold                : 1 holds off the bank write port (no pop)
//   rs1, rs2                 : decode source queries
//   rs1Pending, rs2Pending   : a write to that source is queued or in flight
//   wbRd, wbData, wbRegWrite : bank rd, writeData and regWrite (active-low)
//   count                    : FIFO occupancy
//   rsXFwd, rsXHit           : (WB_BYPASS_EN) youngest pending data for rsX
// ----------------------------------------------------------------------------
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   aluValid,
    input  logic [4:0]             aluRd,
    input  logic [XLEN-1:0]        aluData,
    output logic                   aluReady,
    input  logic                   ldValid,
    input  logic [4:0]             ldRd,
    input  logic [XLEN-1:0]        ldData,
    output logic                   ldReady,
    input  logic                   drainHold,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    output logic                   rs1Pending,
    output logic                   rs2Pending,
    output logic [4:0]             wbRd,
    output logic [XLEN-1:0]        wbData,
    output logic                   wbRegWrite,
    output logic [$clog2(DEPTH):0] count
`ifdef WB_BYPASS_EN
    ,
    output logic [XLEN-1:0]        rs1Fwd,
    output logic [XLEN-1:0]        rs2Fwd,
    output logic                   rs1Hit,
    output logic                   rs2Hit
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]              fifo_count;
    logic [4:0]                 head_rd;
    logic [XLEN-1:0]            head_data;
    logic [DEPTH-1:0]           age_valid;
    logic [DEPTH-1:0][4:0]      age_rd;
    logic [DEPTH-1:0][XLEN-1:0] age_data;

    logic            space;
    logic            pop;
    logic            transfer;
    logic            store;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;

    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic            wb_regwrite_reg;

    // ------------------------------------------------------------------
    // Push arbitration. A full queue still has room when a pop happens in
    // the same cycle, so it can take a new entry without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        pop       = (fifo_count != '0) && !drainHold;
        space     = (fifo_count < CW'(DEPTH)) || pop;
        ldReady   = space;
        aluReady  = space && !ldValid;
        transfer  = (ldValid && ldReady) || (aluValid && aluReady);
        push_rd   = ldValid ? ldRd   : aluRd;
        push_data = ldValid ? ldData : aluData;
        // An x0 result is handshaken normally but never stored.
        store     = transfer && (push_rd != REG_ZERO);
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (store),
        .push_rd   (push_rd),
        .push_data (push_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (fifo_count),
        .age_valid (age_valid),
        .age_rd    (age_rd),
        .age_data  (age_data)
    );

    // ------------------------------------------------------------------
    // Output stage. This register drives the bank for one cycle per pop.
    // rd/data hold between writes; only the strobe returns to idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_rd_reg       <= REG_ZERO;
            wb_data_reg     <= '0;
            wb_regwrite_reg <= WB_IDLE;
        end else if (pop) begin
            wb_rd_reg       <= head_rd;
            wb_data_reg     <= head_data;
            wb_regwrite_reg <= WB_WRITE;
        end else begin
            wb_regwrite_reg <= WB_IDLE;
        end
    end

    assign wbRd       = wb_rd_reg;
    assign wbData     = wb_data_reg;
    assign wbRegWrite = wb_regwrite_reg;
    assign count      = fifo_count;

    // ------------------------------------------------------------------
    // Pending scoreboard (and optional forwarding), one block per source.
    // These signals come from state only, so the push of the current cycle
    // is not visible yet. Slot order is oldest first, so a later matching
    // slot overrides an earlier one. The output stage is older than every
    // queued entry, so it has the lowest priority.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [4:0]       rs;
        logic [DEPTH-1:0] entry_hit;
        logic             out_hit;
        logic             pending;

        assign rs = (gi == 0) ? rs1 : rs2;

        always_comb begin
            entry_hit = '0;
            for (int k = 0; k < DEPTH; k++) begin
                entry_hit[k] = age_valid[k] && rd_match(rs, age_rd[k]);
            end
            out_hit = (wb_regwrite_reg == WB_WRITE) && rd_match(rs, wb_rd_reg);
            pending = (|entry_hit) || out_hit;
        end

`ifdef WB_BYPASS_EN
        logic [XLEN-1:0] fwd;

        always_comb begin
            fwd = '0;
            if (out_hit) begin
                fwd = wb_data_reg;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (entry_hit[k]) begin
                    fwd = age_data[k];
                end
            end
        end
`endif
    end

    assign rs1Pending = g_src[0].pending;
    assign rs2Pending = g_src[1].pending;

`ifdef WB_BYPASS_EN
    assign rs1Hit = g_src[0].pending;
    assign rs2Hit = g_src[1].pending;
    assign rs1Fwd = g_src[0].fwd;
    assign rs2Fwd = g_src[1].fwd;
`else
    // Queued data is only needed for forwarding.
    logic unused_age_data;
    assign unused_age_data = ^age_data;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            aluValid;
    logic [4:0]      aluRd;
    logic [XLEN-1:0] aluData;
    logic            aluReady;
    logic            ldValid;
    logic [4:0]      ldRd;
    logic [XLEN-1:0] ldData;
    logic            ldReady;
    logic            drainHold;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1Pending;
    logic            rs2Pending;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbData;
    logic            wbRegWrite;
    logic [2:0]      count;
`ifdef WB_BYPASS_EN
    logic [XLEN-1:0] rs1Fwd;
    logic [XLEN-1:0] rs2Fwd;
    logic            rs1Hit;
    logic            rs2Hit;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    wb_entry_t exp_q[$];

    always #5 clock = ~clock;

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .aluValid   (aluValid),
        .aluRd      (aluRd),
        .aluData    (aluData),
        .aluReady   (aluReady),
        .ldValid    (ldValid),
        .ldRd       (ldRd),
        .ldData     (ldData),
        .ldReady    (ldReady),
        .drainHold  (drainHold),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1Pending (rs1Pending),
        .rs2Pending (rs2Pending),
        .wbRd       (wbRd),
        .wbData     (wbData),
        .wbRegWrite (wbRegWrite),
        .count      (count)
`ifdef WB_BYPASS_EN
        ,
        .rs1Fwd     (rs1Fwd),
        .rs2Fwd     (rs2Fwd),
        .rs1Hit     (rs1Hit),
        .rs2Hit     (rs2Hit)
`endif
    );

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [XLEN-1:0] data);
        aluValid = 1'b1;
        aluRd    = rd;
        aluData  = data;
        #1;
        check($sformatf("alu_ready_rd%0d", rd), aluReady, 1'b1);
        if (rd != REG_ZERO) expect_write(rd, data);
        step();
        aluValid = 1'b0;
    endtask

    // Scoreboard: every bank write must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && wbRegWrite === 1'b0) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fails++;
                $error("FAIL unexpected_write: observed rd %0d data %0h expected no write", wbRd, wbData);
            end
            if (exp_q.size() != 0) begin
                wb_entry_t e;
                e = exp_q.pop_front();
                n_checks++;
                assert ({wbRd, wbData} === {e.rd, e.data}) else begin
                    n_fails++;
                    $error("FAIL write_order: observed rd %0d data %0h expected rd %0d data %0h",
                           wbRd, wbData, e.rd, e.data);
                end
                $display("write rd=%0d data=%0h", wbRd, wbData);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; aluValid = 1'b0; aluRd = '0; aluData = '0;
        ldValid = 1'b0; ldRd = '0; ldData = '0; drainHold = 1'b0;
        rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clock);
        #2;
        check("reset_count", count, 0);
        check("reset_regwrite", wbRegWrite, 1);
        check("reset_rd", wbRd, 0);
        check("reset_data", wbData, 0);
        reset = 1'b0;
        step();

        // Single ALU write: latency and pending window.
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h1234; rs1 = 5'd5;
        #1;
        check("t1_alu_ready", aluReady, 1);
        check("t1_pending_push_excluded", rs1Pending, 0);
        expect_write(5'd5, 32'h1234);
        step();
        aluValid = 1'b0;
        check("t1_count_after_push", count, 1);
        check("t1_regwrite_n", wbRegWrite, 1);
        check("t1_pending_queued", rs1Pending, 1);
        step();
        check("t1_regwrite_n1", wbRegWrite, 0);
        check("t1_wbrd", wbRd, 5);
        check("t1_wbdata", wbData, 32'h1234);
        check("t1_pending_inflight", rs1Pending, 1);
        step();
        check("t1_regwrite_n2", wbRegWrite, 1);
        check("t1_pending_done", rs1Pending, 0);

        // Load beats ALU; ALU offer held and accepted next cycle.
        ldValid = 1'b1; ldRd = 5'd3; ldData = 32'h33;
        aluValid = 1'b1; aluRd = 5'd4; aluData = 32'h44;
        #1;
        check("t2_ld_ready", ldReady, 1);
        check("t2_alu_ready_blocked", aluReady, 0);
        expect_write(5'd3, 32'h33);
        step();
        ldValid = 1'b0;
        #1;
        check("t2_alu_ready_next", aluReady, 1);
        expect_write(5'd4, 32'h44);
        step();
        aluValid = 1'b0;
        check("t2_first_rd", wbRd, 3);
        check("t2_first_we", wbRegWrite, 0);
        step();
        check("t2_second_rd", wbRd, 4);
        check("t2_second_we", wbRegWrite, 0);
        step();
        check("t2_idle", wbRegWrite, 1);

        // Writes to x0 are handshaken but dropped.
        offer_alu(5'd0, 32'hDEAD);
        check("t3_count_x0", count, 0);
        step();
        check("t3_no_write", wbRegWrite, 1);

        // Empty queue with drainHold toggling: no effect.
        drainHold = 1'b1;
        step();
        drainHold = 1'b0;
        step();
        check("t3b_empty_toggle", wbRegWrite, 1);

        // Fill under drainHold, then release.
        drainHold = 1'b1;
        for (int i = 1; i <= 4; i++) offer_alu(5'(i), 32'h100 + i);
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h105;
        ldValid = 1'b1; ldRd = 5'd6; ldData = 32'h106;
        rs1 = 5'd3; rs2 = 5'd7;
        #1;
        check("t4_count_full", count, 4);
        check("t4_alu_ready_full", aluReady, 0);
        check("t4_ld_ready_full", ldReady, 0);
        check("t4_rs1_pending", rs1Pending, 1);
        check("t4_rs2_pending", rs2Pending, 0);
        step();
        aluValid = 1'b0; ldValid = 1'b0;
        check("t4_count_held", count, 4);
        drainHold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t4_drain_rd%0d", i), wbRd, i);
            check($sformatf("t4_drain_we%0d", i), wbRegWrite, 0);
            check($sformatf("t4_rs1_pending_after%0d", i), rs1Pending, (i <= 3) ? 1 : 0);
        end
        step();
        check("t4_drained_count", count, 0);
        check("t4_drained_we", wbRegWrite, 1);

        // Full, drainHold released, push offered: push and pop together.
        drainHold = 1'b1;
        for (int i = 10; i <= 13; i++) offer_alu(5'(i), 32'h200 + i);
        drainHold = 1'b0;
        aluValid = 1'b1; aluRd = 5'd14; aluData = 32'h20E;
        #1;
        check("t5_count_before", count, 4);
        check("t5_alu_ready_full_pop", aluReady, 1);
        expect_write(5'd14, 32'h20E);
        step();
        aluValid = 1'b0;
        check("t5_count_same", count, 4);
        check("t5_first_rd", wbRd, 10);
        repeat (5) step();
        check("t5_count_end", count, 0);
        check("t5_we_end", wbRegWrite, 1);

        // Asynchronous reset with three entries queued.
        drainHold = 1'b1;
        for (int i = 20; i <= 22; i++) offer_alu(5'(i), 32'h300 + i);
        rs1 = 5'd21;
        check("t6_count3", count, 3);
        reset = 1'b1;
        #1;
        check("t6_async_count", count, 0);
        check("t6_async_we", wbRegWrite, 1);
        check("t6_async_pending", rs1Pending, 0);
        exp_q.delete();
        drainHold = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        check("t6_post_count", count, 0);
        check("t6_post_we", wbRegWrite, 1);

`ifdef WB_BYPASS_EN
        // Forwarding: the youngest write to rd 9 wins.
        drainHold = 1'b1;
        offer_alu(5'd9, 32'h11);
        offer_alu(5'd9, 32'h22);
        rs1 = 5'd9; rs2 = 5'd7;
        #1;
        check("t7_rs1_hit", rs1Hit, 1);
        check("t7_rs1_fwd", rs1Fwd, 32'h22);
        check("t7_rs2_hit", rs2Hit, 0);
        check("t7_rs2_fwd", rs2Fwd, 0);
        drainHold = 1'b0;
        step();
        check("t7_fwd_mixed", rs1Fwd, 32'h22);
        step();
        check("t7_fwd_outstage", rs1Fwd, 32'h22);
        check("t7_hit_outstage", rs1Hit, 1);
        step();
        check("t7_hit_done", rs1Hit, 0);
        check("t7_fwd_done", rs1Fwd, 0);
`endif

        step();
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
